// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-side prediction and EX-side training signals of the branch predictor
interface branch_predictor_if #(
  parameter int INDEX_BITS = 6
);
  logic [31:0] fetch_pc;
  logic fetch_is_branch;
  logic [31:0] fetch_offset;
  logic predict_taken;
  logic [31:0] predict_target;
  logic [INDEX_BITS-1:0] fetch_index;
  logic ex_valid;
  logic [INDEX_BITS-1:0] ex_index;
  logic ex_branch_enable;
  logic ex_predicted;
  logic mispredict;
  logic ready;
  modport master (
    output fetch_pc, fetch_is_branch, fetch_offset, ex_valid, ex_index, ex_branch_enable, ex_predicted,
    input predict_taken, predict_target, fetch_index, mispredict, ready
  );
  modport slave (
    input fetch_pc, fetch_is_branch, fetch_offset, ex_valid, ex_index, ex_branch_enable, ex_predicted,
    output predict_taken, predict_target, fetch_index, mispredict, ready
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating counter predictor trained from EX outcomes; define BPRED_GSHARE_EN for gshare indexing
module branch_predictor #(
  parameter int INDEX_BITS = 6
`ifdef BPRED_GSHARE_EN
  , parameter int HIST_BITS = 6
`endif
) (
  input logic clk,
  input logic reset_n,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 2 ** INDEX_BITS;
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  logic ready_q, ready_d, mispredict_q, mispredict_d;
  logic [1:0] tbl [ENTRIES];
  logic [INDEX_BITS-1:0] pc_index, fetch_index, waddr;
  logic [1:0] ex_ctr, wdata;
  logic init, train, we;
  assign pc_index = bp.fetch_pc[INDEX_BITS+1:2];
`ifdef BPRED_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  assign fetch_index = pc_index ^ INDEX_BITS'(ghr_q);
`else
  assign fetch_index = pc_index;
`endif
  always_comb begin
    init = state_q == INIT;
    train = state_q == RUN && bp.ex_valid;
    ex_ctr = tbl[bp.ex_index];
    state_d = (init && &sweep_q) ? RUN : state_q;
    sweep_d = init ? sweep_q + 1'b1 : sweep_q;
    ready_d = ready_q | (init & &sweep_q);
    mispredict_d = train & (bp.ex_branch_enable != bp.ex_predicted);
    we = reset_n & (init | train);
    waddr = init ? sweep_q : bp.ex_index;
    wdata = init ? 2'b01
          : bp.ex_branch_enable ? ((ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'b01)
          : ((ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'b01);
`ifdef BPRED_GSHARE_EN
    ghr_d = train ? {ghr_q[HIST_BITS-2:0], bp.ex_branch_enable} : ghr_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
      mispredict_q <= 1'b0;
`ifdef BPRED_GSHARE_EN
      ghr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ready_q <= ready_d;
      mispredict_q <= mispredict_d;
`ifdef BPRED_GSHARE_EN
      ghr_q <= ghr_d;
`endif
    end
  end
  // Counter table carries no reset so it can map onto block RAM
  always_ff @(posedge clk)
    if (we) tbl[waddr] <= wdata;
  assign bp.fetch_index = fetch_index;
  assign bp.predict_taken = ready_q & bp.fetch_is_branch & tbl[fetch_index][1];
  assign bp.predict_target = bp.fetch_pc + bp.fetch_offset;
  assign bp.mispredict = mispredict_q;
  assign bp.ready = ready_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of init sweep, training, saturation, mispredict and read-during-write
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  branch_predictor_if #(.INDEX_BITS(6)) bp ();
  branch_predictor #(.INDEX_BITS(6)) dut (.clk(clk), .reset_n(reset_n), .bp(bp.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic train(input logic [5:0] idx, input logic be, input logic pred);
    bp.ex_valid = 1'b1;
    bp.ex_index = idx;
    bp.ex_branch_enable = be;
    bp.ex_predicted = pred;
    tick;
    bp.ex_valid = 1'b0;
  endtask
  task automatic init_sweep;
    for (int i = 0; i < 64; i++) begin
      bp.fetch_pc = 32'(i * 4);
      bp.fetch_is_branch = 1'b1;
      bp.ex_valid = (i == 62);
      bp.ex_index = 6'd3;
      bp.ex_branch_enable = 1'b1;
      bp.ex_predicted = 1'b0;
      #1;
      chk("init_pred", 32'(bp.predict_taken), 32'd0);
      chk("init_ready_low", 32'(bp.ready), 32'd0);
      tick;
      chk("init_misp", 32'(bp.mispredict), 32'd0);
    end
    bp.ex_valid = 1'b0;
  endtask
  initial begin
    bp.fetch_pc = '0;
    bp.fetch_is_branch = 1'b0;
    bp.fetch_offset = '0;
    bp.ex_valid = 1'b0;
    bp.ex_index = '0;
    bp.ex_branch_enable = 1'b0;
    bp.ex_predicted = 1'b0;
    tick;
    tick;
    chk("rst_ready", 32'(bp.ready), 32'd0);
    chk("rst_misp", 32'(bp.mispredict), 32'd0);
    reset_n = 1'b1;
    init_sweep();
    chk("init_done_ready", 32'(bp.ready), 32'd1);
    bp.fetch_pc = 32'h14;
    bp.fetch_offset = 32'hFFFF_FFF0;
    bp.fetch_is_branch = 1'b1;
    #1;
    chk("idx5_weak_nt", 32'(bp.predict_taken), 32'd0);
    chk("fetch_index_5", 32'(bp.fetch_index), 32'd5);
    train(6'd5, 1'b1, 1'b0);
    chk("misp_first", 32'(bp.mispredict), 32'd1);
    train(6'd5, 1'b1, 1'b0);
    #1;
    chk("train_pred", 32'(bp.predict_taken), 32'd1);
    chk("target_neg", bp.predict_target, 32'h4);
    for (int i = 0; i < 3; i++) begin
      train(6'd5, 1'b1, 1'b1);
      chk("misp_correct", 32'(bp.mispredict), 32'd0);
    end
    train(6'd5, 1'b0, 1'b1);
    #1;
    chk("sat_hi_nt1", 32'(bp.predict_taken), 32'd1);
    train(6'd5, 1'b0, 1'b1);
    #1;
    chk("sat_hi_nt2", 32'(bp.predict_taken), 32'd0);
    for (int i = 0; i < 3; i++) train(6'd5, 1'b0, 1'b0);
    train(6'd5, 1'b1, 1'b0);
    #1;
    chk("sat_lo_t1", 32'(bp.predict_taken), 32'd0);
    train(6'd9, 1'b1, 1'b0);
    chk("misp_pulse", 32'(bp.mispredict), 32'd1);
    tick;
    chk("misp_drop", 32'(bp.mispredict), 32'd0);
    train(6'd9, 1'b1, 1'b1);
    chk("misp_none", 32'(bp.mispredict), 32'd0);
    bp.ex_valid = 1'b1;
    bp.ex_index = 6'd9;
    bp.ex_branch_enable = 1'b1;
    bp.ex_predicted = 1'b0;
    tick;
    chk("misp_b2b_1", 32'(bp.mispredict), 32'd1);
    tick;
    chk("misp_b2b_2", 32'(bp.mispredict), 32'd1);
    bp.ex_valid = 1'b0;
    tick;
    chk("misp_b2b_end", 32'(bp.mispredict), 32'd0);
    bp.fetch_pc = 32'h1C;
    bp.fetch_offset = 32'h0;
    #1;
    chk("fetch_index_7", 32'(bp.fetch_index), 32'd7);
    bp.ex_valid = 1'b1;
    bp.ex_index = 6'd7;
    bp.ex_branch_enable = 1'b1;
    bp.ex_predicted = 1'b0;
    #1;
    chk("rdw_same_cycle", 32'(bp.predict_taken), 32'd0);
    tick;
    chk("rdw_next_cycle", 32'(bp.predict_taken), 32'd1);
    tick;
    bp.ex_branch_enable = 1'b0;
    bp.ex_predicted = 1'b1;
    tick;
    tick;
    bp.ex_valid = 1'b0;
    #1;
    chk("b2b_no_lost", 32'(bp.predict_taken), 32'd0);
    bp.fetch_pc = 32'h24;
    #1;
    chk("idx9_taken", 32'(bp.predict_taken), 32'd1);
    bp.fetch_is_branch = 1'b0;
    #1;
    chk("not_branch", 32'(bp.predict_taken), 32'd0);
    bp.fetch_pc = 32'hFFFF_FFFC;
    bp.fetch_offset = 32'h8;
    #1;
    chk("target_wrap", bp.predict_target, 32'h4);
    bp.fetch_is_branch = 1'b1;
    bp.fetch_pc = 32'h14;
    train(6'd5, 1'b1, 1'b0);
    train(6'd5, 1'b1, 1'b0);
    #1;
    chk("pre_reset_taken", 32'(bp.predict_taken), 32'd1);
    reset_n = 1'b0;
    bp.ex_valid = 1'b1;
    bp.ex_index = 6'd5;
    bp.ex_branch_enable = 1'b1;
    bp.ex_predicted = 1'b0;
    tick;
    chk("rerst_misp", 32'(bp.mispredict), 32'd0);
    chk("rerst_ready", 32'(bp.ready), 32'd0);
    tick;
    bp.ex_valid = 1'b0;
    reset_n = 1'b1;
    init_sweep();
    chk("reinit_ready", 32'(bp.ready), 32'd1);
    bp.fetch_pc = 32'h14;
    bp.fetch_is_branch = 1'b1;
    #1;
    chk("reinit_idx5", 32'(bp.predict_taken), 32'd0);
`ifdef BPRED_GSHARE_EN
    train(6'd10, 1'b1, 1'b1);
    train(6'd10, 1'b0, 1'b0);
    train(6'd10, 1'b1, 1'b1);
    #1;
    chk("gshare_index", 32'(bp.fetch_index), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
